// File: rtl/param_hex_counter_if.sv
// Bus bundle for param_hex_counter: control inputs, count, flags and 7-segment codes.
// The master drives control; the slave (the counter) drives Q, TC, Wrapped and HEX.
interface param_hex_counter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned NUM_DIGITS = WIDTH / 4;

    logic                      Enable;
    logic                      Up;
    logic                      Saturate;
    logic                      Load;
    logic [WIDTH-1:0]          LoadValue;
    logic [WIDTH-1:0]          Q;
    logic                      TC;
    logic                      Wrapped;
    logic [7*NUM_DIGITS-1:0]   HEX;

    modport master (
        output Enable, Up, Saturate, Load, LoadValue,
        input  Q, TC, Wrapped, HEX
    );

    modport slave (
        input  Enable, Up, Saturate, Load, LoadValue,
        output Q, TC, Wrapped, HEX
    );
endinterface

// File: rtl/param_hex_counter.sv
// Parametrised up/down counter with wrap/saturate, load, TC/Wrapped flags and per-nibble
// active-low 7-segment decode. Define COUNTER_PRESCALE_EN to add the PRESCALE step divider.
module param_hex_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                   Clk,
    input  logic                   Clear,
    param_hex_counter_if.slave     bus
);
    localparam int unsigned NUM_DIGITS = WIDTH / 4;
    // MODULUS-1 always fits in WIDTH bits, so comparisons never need a wider operand.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    if (WIDTH == 0 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("param_hex_counter: WIDTH must be a nonzero multiple of 4");
    end
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("param_hex_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("param_hex_counter: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic             wrapped_q;
    logic             wrap_next;
    logic             tick_c;
    logic             at_max_c;
    logic             at_zero_c;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale;

    assign tick_c = bus.Enable && (prescale == PS_LAST);

    // Prescaler advances only while enabled and restarts on every step, Clear or Load.
    always_ff @(posedge Clk) begin
        if (Clear || bus.Load || tick_c) begin
            prescale <= '0;
        end else if (bus.Enable) begin
            prescale <= prescale + PS_W'(1);
        end
    end
`else
    assign tick_c = bus.Enable;
`endif

    assign at_max_c  = (q == MAX_Q);
    assign at_zero_c = (q == '0);

    // Next count and wrap event for a pending step.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (tick_c) begin
            if (bus.Up) begin
                if (!at_max_c) begin
                    q_next = q + WIDTH'(1);
                end else if (!bus.Saturate) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_zero_c) begin
                    q_next = q - WIDTH'(1);
                end else if (!bus.Saturate) begin
                    q_next    = MAX_Q;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            q         <= '0;
            wrapped_q <= 1'b0;
        end else if (bus.Load) begin
            q         <= (bus.LoadValue > MAX_Q) ? MAX_Q : bus.LoadValue;
            wrapped_q <= 1'b0;
        end else begin
            q         <= q_next;
            wrapped_q <= wrap_next;
        end
    end

    assign bus.Q       = q;
    assign bus.Wrapped = wrapped_q;
    assign bus.TC      = tick_c & ((bus.Up & at_max_c) | (~bus.Up & at_zero_c));

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign bus.HEX[7*i +: 7] = seg7(q[4*i +: 4]);
    end
endmodule

// File: tb/tb_param_hex_counter.sv
// Scoreboard bench for param_hex_counter: directed steps push hand-derived expectations,
// a negedge monitor pops them and compares Q, TC, Wrapped and HEX of the selected instance.
module tb_param_hex_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear_a;
    logic clear_b;
    param_hex_counter_if #(.WIDTH(8)) bus_a ();
    param_hex_counter_if #(.WIDTH(8)) bus_b ();

    param_hex_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) u_a (
        .Clk(clk), .Clear(clear_a), .bus(bus_a)
    );
    param_hex_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) u_b (
        .Clk(clk), .Clear(clear_b), .bus(bus_b)
    );

`ifdef COUNTER_PRESCALE_EN
    logic clear_c;
    param_hex_counter_if #(.WIDTH(8)) bus_c ();
    param_hex_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(4)) u_c (
        .Clk(clk), .Clear(clear_c), .bus(bus_c)
    );
`endif

    typedef struct packed {
        int unsigned  sel;
        logic [7:0]   q;
        logic         tc;
        logic         wr;
        logic [95:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic void chk(input logic [95:0] tag, input logic [63:0] what,
                                input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %0s.%0s: got %0h, expected %0h (t=%0t)", tag, what, act, exp, $time);
        end
    endfunction

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin : mon
            exp_t        e;
            logic [7:0]  aq;
            logic        atc;
            logic        awr;
            logic [13:0] ahex;
            e = sb.pop_front();
            case (e.sel)
                0: begin aq = bus_a.Q; atc = bus_a.TC; awr = bus_a.Wrapped; ahex = bus_a.HEX; end
                1: begin aq = bus_b.Q; atc = bus_b.TC; awr = bus_b.Wrapped; ahex = bus_b.HEX; end
`ifdef COUNTER_PRESCALE_EN
                2: begin aq = bus_c.Q; atc = bus_c.TC; awr = bus_c.Wrapped; ahex = bus_c.HEX; end
`endif
                default: begin aq = 'x; atc = 1'bx; awr = 1'bx; ahex = 'x; end
            endcase
            chk(e.tag, "Q",       32'(aq),   32'(e.q));
            chk(e.tag, "TC",      32'(atc),  32'(e.tc));
            chk(e.tag, "Wrapped", 32'(awr),  32'(e.wr));
            chk(e.tag, "HEX",     32'(ahex), 32'({seg(e.q[7:4]), seg(e.q[3:0])}));
        end
    end

    task automatic idle_all();
        clear_a = 1'b0; bus_a.Enable = 1'b0; bus_a.Load = 1'b0;
        clear_b = 1'b0; bus_b.Enable = 1'b0; bus_b.Load = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        clear_c = 1'b0; bus_c.Enable = 1'b0; bus_c.Load = 1'b0;
`endif
    endtask

    // Drive one cycle on instance s; eq/etc/ewr are what that instance shows during this cycle.
    task automatic step(input int unsigned s, input logic clr, input logic en, input logic up,
                        input logic sat, input logic ld, input logic [7:0] lv,
                        input logic [7:0] eq, input logic etc, input logic ewr,
                        input logic [95:0] tag);
        exp_t e;
        @(posedge clk);
        #1;
        idle_all();
        case (s)
            0: begin clear_a = clr; bus_a.Enable = en; bus_a.Up = up; bus_a.Saturate = sat;
                     bus_a.Load = ld; bus_a.LoadValue = lv; end
            1: begin clear_b = clr; bus_b.Enable = en; bus_b.Up = up; bus_b.Saturate = sat;
                     bus_b.Load = ld; bus_b.LoadValue = lv; end
`ifdef COUNTER_PRESCALE_EN
            2: begin clear_c = clr; bus_c.Enable = en; bus_c.Up = up; bus_c.Saturate = sat;
                     bus_c.Load = ld; bus_c.LoadValue = lv; end
`endif
            default: ;
        endcase
        e.sel = s; e.q = eq; e.tc = etc; e.wr = ewr; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        idle_all();
        clear_a = 1'b1; clear_b = 1'b1;
        bus_a.Up = 1'b1; bus_a.Saturate = 1'b0; bus_a.LoadValue = '0;
        bus_b.Up = 1'b1; bus_b.Saturate = 1'b0; bus_b.LoadValue = '0;
`ifdef COUNTER_PRESCALE_EN
        clear_c = 1'b1; bus_c.Up = 1'b1; bus_c.Saturate = 1'b0; bus_c.LoadValue = '0;
`endif

        // Reset state of every instance.
        step(0, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, "reset_a");
        step(1, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, "reset_b");

        // MODULUS=256 free run: 0..255, wraps to 0 at cycle 256, ends at 4.
        for (int j = 0; j < 260; j++)
            step(0, 0, 1, 1, 0, 0, 8'd0, 8'(j % 256), (j == 255), (j == 256), "up_wrap");
        step(0, 0, 0, 1, 0, 0, 8'd0, 8'd4, 0, 0, "end_at_4");

        // MODULUS=10 down-wrap then saturate at 0.
        step(1, 0, 1, 0, 0, 0, 8'd0,   8'd0, 1, 0, "dn_tc0");
        step(1, 0, 0, 0, 0, 0, 8'd0,   8'd9, 0, 1, "dn_wrap9");
        step(1, 0, 0, 0, 0, 1, 8'd0,   8'd9, 0, 0, "ld0");
        step(1, 0, 1, 0, 1, 0, 8'd0,   8'd0, 1, 0, "dn_sat0");
        step(1, 0, 1, 0, 1, 0, 8'd0,   8'd0, 1, 0, "dn_sat0");
        step(1, 0, 1, 0, 1, 0, 8'd0,   8'd0, 1, 0, "dn_sat0");
        // Up saturate at 9, then up wrap 9->0.
        step(1, 0, 0, 1, 0, 1, 8'd9,   8'd0, 0, 0, "ld9");
        step(1, 0, 1, 1, 1, 0, 8'd0,   8'd9, 1, 0, "up_sat9");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd9, 1, 0, "up_wrap9");
        step(1, 0, 0, 1, 0, 0, 8'd0,   8'd0, 0, 1, "up_wrapped");
        // Load beats Enable; out-of-range load clamps to 9.
        step(1, 0, 1, 1, 0, 1, 8'd7,   8'd0, 0, 0, "ld7_en");
        step(1, 0, 1, 1, 0, 1, 8'd200, 8'd7, 0, 0, "ld200_en");
        step(1, 0, 0, 1, 0, 0, 8'd0,   8'd9, 0, 0, "clamp9");
        // Clear beats Load and Enable, counting resumes afterwards.
        step(1, 0, 0, 1, 0, 1, 8'd5,   8'd9, 0, 0, "ld5");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd5, 0, 0, "cnt5");
        step(1, 1, 1, 1, 0, 1, 8'd3,   8'd6, 0, 0, "clr_ld_en");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd0, 0, 0, "resume0");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd1, 0, 0, "resume1");
        step(1, 0, 0, 1, 0, 0, 8'd0,   8'd2, 0, 0, "resume2");
        // Clear in the cycle Wrapped is high.
        step(1, 0, 0, 1, 0, 1, 8'd9,   8'd2, 0, 0, "ld9b");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd9, 1, 0, "wrap_pre_clr");
        step(1, 1, 1, 1, 0, 0, 8'd0,   8'd0, 0, 1, "clr_on_wr");
        step(1, 0, 0, 1, 0, 0, 8'd0,   8'd0, 0, 0, "after_clr");
        // Direction toggled every step from 3, then Enable low freezes Q and TC.
        step(1, 0, 0, 1, 0, 1, 8'd3,   8'd0, 0, 0, "ld3");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd3, 0, 0, "tog_up");
        step(1, 0, 1, 0, 0, 0, 8'd0,   8'd4, 0, 0, "tog_dn");
        step(1, 0, 1, 1, 0, 0, 8'd0,   8'd3, 0, 0, "tog_up");
        step(1, 0, 1, 0, 0, 0, 8'd0,   8'd4, 0, 0, "tog_dn");
        step(1, 0, 0, 0, 0, 0, 8'd0,   8'd3, 0, 0, "frozen");
        step(1, 0, 0, 0, 0, 1, 8'd0,   8'd3, 0, 0, "ld0b");
        step(1, 0, 0, 0, 0, 0, 8'd0,   8'd0, 0, 0, "tc_no_en");

`ifdef COUNTER_PRESCALE_EN
        // PRESCALE=4: steps on every 4th enabled edge; a 2-cycle Enable gap delays by 2.
        step(2, 0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, "reset_c");
        for (int j = 0; j < 13; j++)
            step(2, 0, 1, 1, 0, 0, 8'd0, 8'(j / 4), 0, 0, "ps_run");
        step(2, 0, 0, 1, 0, 0, 8'd0, 8'd3, 0, 0, "ps_gap");
        step(2, 0, 0, 1, 0, 0, 8'd0, 8'd3, 0, 0, "ps_gap");
        step(2, 0, 1, 1, 0, 0, 8'd0, 8'd3, 0, 0, "ps_resume");
        step(2, 0, 1, 1, 0, 0, 8'd0, 8'd3, 0, 0, "ps_resume");
        step(2, 0, 1, 1, 0, 0, 8'd0, 8'd3, 0, 0, "ps_resume");
        step(2, 0, 0, 1, 0, 1, 8'd255, 8'd4, 0, 0, "ps_step4");
        // TC only on the tick cycle of each prescale period.
        step(2, 0, 1, 1, 1, 0, 8'd0, 8'd255, 0, 0, "ps_tc");
        step(2, 0, 1, 1, 1, 0, 8'd0, 8'd255, 0, 0, "ps_tc");
        step(2, 0, 1, 1, 1, 0, 8'd0, 8'd255, 0, 0, "ps_tc");
        step(2, 0, 1, 1, 1, 0, 8'd0, 8'd255, 1, 0, "ps_tc");
        step(2, 0, 0, 1, 1, 0, 8'd0, 8'd255, 0, 0, "ps_hold");
`endif

        @(posedge clk);
        #1;
        idle_all();
        repeat (3) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/param_hex_counter.md
Name: param_hex_counter

Overview:
Parametrised synchronous up/down counter, successor to the fixed 8-bit T-flip-flop counter with two-digit hex display. Adds:
- configurable width and modulus
- direction control and parallel load
- wrap or saturate mode
- terminal-count and wrap-event flags
- one active-low 7-segment code per 4-bit nibble, driving the board HEX displays directly.

Parameters:
WIDTH, 8, counter width in bits; must be a multiple of 4.
MODULUS, 256, count range is 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
PRESCALE, 4, clock cycles per count step; used only with COUNTER_PRESCALE_EN; must be >= 1.
Derived, not a parameter: NUM_DIGITS = WIDTH/4.

Ports:
Clk  in  1  rising-edge clock.
Clear  in  1  synchronous active-high reset.
Enable  in  1  count enable.
Up  in  1  1 = count up, 0 = count down.
Saturate  in  1  1 = hold at range end, 0 = wrap around.
Load  in  1  parallel load strobe.
LoadValue  in  WIDTH  value loaded on Load.
Q  out  WIDTH  current count.
TC  out  1  terminal count; combinational.
Wrapped  out  1  registered one-cycle pulse after a wrap.
HEX  out  7*NUM_DIGITS  segment codes; digit i occupies HEX[7i+6:7i].

Behaviour:
- Single clock (Clk). Clear is synchronous and active-high. All state updates on the rising edge of Clk.
- Priority per edge: Clear > Load > count step > hold.
- Clear: Q=0, Wrapped=0, prescaler=0. HEX then shows all digits as 0, i.e. 7'b1000000 per digit.
- Load: Q <= LoadValue if LoadValue < MODULUS, else Q <= MODULUS-1. Wrapped <= 0. Prescaler <= 0. Load overrides Enable in the same cycle.
- tick: the cycle's count-step qualifier.
  - Without COUNTER_PRESCALE_EN: tick = Enable.
- Count step (tick=1, no Clear/Load):
  - Up=1, Q<MODULUS-1: Q <= Q+1.
  - Up=1, Q==MODULUS-1: Q <= 0 if Saturate=0 (Wrapped <= 1); Q holds if Saturate=1 (Wrapped <= 0).
  - Up=0, Q>0: Q <= Q-1.
  - Up=0, Q==0: Q <= MODULUS-1 if Saturate=0 (Wrapped <= 1); Q holds if Saturate=1.
- Wrapped: 1 only for the one cycle following a wrap edge; otherwise 0.
- TC = tick & ((Up & Q==MODULUS-1) | (~Up & Q==0)).
  - Asserts in saturate mode too; it means "at range end with a step pending".
- Up and Saturate are sampled every edge. A direction change takes effect on the very next step. No internal state depends on previous direction.
- HEX:
  - Purely combinational from Q, no latency.
  - Digit i decodes Q[4i+3:4i] to 0-9, A-F.
  - Active-low, bit 0 = segment a ... bit 6 = segment g.
  - Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Arithmetic is WIDTH bits unsigned. The comparisons with MODULUS-1 must not overflow when MODULUS = 2**WIDTH.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - Adds an internal prescale counter, width clog2(PRESCALE), minimum 1 bit.
  - It increments while Enable=1 and is frozen while Enable=0.
  - tick = Enable & (prescale==PRESCALE-1); the prescaler returns to 0 on that cycle.
  - Clear and Load zero the prescaler.
  - PRESCALE=1 behaves identically to the macro undefined.
- Undefined: no prescale logic; tick = Enable; PRESCALE is ignored.

Test Plan:
- WIDTH=8, MODULUS=256. Clear 1 cycle, then Enable=1, Up=1, Saturate=0 for 260 cycles -> Q steps 0..255, reaches 0 on cycle 256, ends at 4; Wrapped high exactly one cycle (after the 255->0 edge); HEX = {1111001,1000000} at Q=0x10.
- WIDTH=8, MODULUS=10, Up=0, Saturate=0, from Q=0 -> TC=1 at Q=0; next edge Q=9, Wrapped=1 next cycle. Then Saturate=1 at Q=0 -> Q holds at 0, TC stays 1, Wrapped stays 0.
- MODULUS=10. Load=1 with LoadValue=7 and Enable=1 in the same cycle -> Q=7, no increment. LoadValue=200 -> Q=9.
- Q=5 counting up. Assert Clear together with Load=1 and Enable=1 -> Q=0, Wrapped=0 next edge. Deassert Clear -> counting resumes 1, 2, ...
- Up toggled every cycle with Enable=1 from Q=3 -> Q sequence 4,3,4,3. Enable=0 -> Q frozen, TC=0.
- COUNTER_PRESCALE_EN, PRESCALE=4, Enable=1 from Clear -> Q increments on every 4th edge (edges 4, 8, 12). Drop Enable for 2 cycles mid-period -> next step delayed by exactly 2 cycles.
